// File: rtl/decode_pkg.sv
// Shared decode definitions for the decode stage and the control unit.
//  imm_fmt_e    : immediate format code. The same encoding is used for
//                 immsrc_i and fmt_o: 0 I, 1 S, 2 B, 3 J, 4 U, 5 illegal.
//  OP_*         : RV32 base opcodes recognised by the decoder.
//  dec_fields_t : decoded instruction fields carried through the stage.
//  opcode_fmt   : maps an opcode to its immediate format.
//  immsrc_fmt   : maps an external format select to a format code.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_J   = 3'd3,
    FMT_U   = 3'd4,
    FMT_ILL = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    imm_fmt_e   fmt;
    logic       illegal;
  } dec_fields_t;

  // R-type has no immediate; it reports format I so that it is not flagged.
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] op);
    imm_fmt_e f;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_REG: f = FMT_I;
      OP_STORE:                                    f = FMT_S;
      OP_BRANCH:                                   f = FMT_B;
      OP_JAL:                                      f = FMT_J;
      OP_LUI, OP_AUIPC:                            f = FMT_U;
      default:                                     f = FMT_ILL;
    endcase
    return f;
  endfunction

  function automatic imm_fmt_e immsrc_fmt(input logic [2:0] src);
    imm_fmt_e f;
    if (src <= 3'd4) f = imm_fmt_e'(src);
    else             f = FMT_ILL;
    return f;
  endfunction

endpackage

// File: rtl/imm_ext.sv
// Immediate builder for the five RV immediate formats.
// Purely combinational; the 32-bit immediate is sign-extended from bit 31
// to XLEN. Format FMT_ILL yields zero.
//  instr  in  [31:7]  instruction word above the opcode
//  fmt    in  3       immediate format
//  immext out XLEN    sign-extended immediate
module imm_ext
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]             instr,
  input  imm_fmt_e                fmt,
  output logic signed [XLEN-1:0]  immext
);

  logic signed [31:0] imm32;

  always_comb begin
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    immext = XLEN'(imm32);
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered decode stage between fetch and execute.
// Splits an RV instruction into fields, builds the sign-extended immediate
// and flags unknown opcodes. A main entry drives the outputs and a one-entry
// skid buffer absorbs the instruction accepted while main is held, giving
// full throughput under backpressure. flush_i discards both entries.
//  clk, rst              clock, asynchronous active-high reset
//  flush_i               discard held entries (highest priority)
//  in_valid/in_ready     upstream handshake (in_ready = !skid valid)
//  instr_i, immsrc_i     instruction word, format select when AUTO_FMT=0
//  out_valid/out_ready   downstream handshake
//  op_o..funct7_o        instruction fields
//  immext_o, fmt_o       immediate and format used
//  illegal_o             unknown opcode or illegal format select
module instr_decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AUTO_FMT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      op_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] immext_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  typedef struct packed {
    dec_fields_t             f;
    logic signed [XLEN-1:0]  imm;
  } entry_t;

  imm_fmt_e               opfmt_p0;
  imm_fmt_e               fmt_p0;
  imm_fmt_e               immsel_p0;
  logic signed [XLEN-1:0] imm_p0;
  entry_t                 dec_p0;

  entry_t main_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   accept;

  // ---- stage 0: combinational decode of the offered instruction ----
  always_comb begin
    opfmt_p0  = opcode_fmt(instr_i[6:0]);
    fmt_p0    = (AUTO_FMT != 0) ? opfmt_p0 : immsrc_fmt(immsrc_i);
    immsel_p0 = fmt_p0;
    // R-type reports format I but carries a zero immediate
    if (AUTO_FMT != 0 && instr_i[6:0] == OP_REG) immsel_p0 = FMT_ILL;
  end

  imm_ext #(.XLEN(XLEN)) u_imm_ext (
    .instr  (instr_i[31:7]),
    .fmt    (immsel_p0),
    .immext (imm_p0)
  );

  always_comb begin
    dec_p0.f.op      = instr_i[6:0];
    dec_p0.f.rd      = instr_i[11:7];
    dec_p0.f.funct3  = instr_i[14:12];
    dec_p0.f.rs1     = instr_i[19:15];
    dec_p0.f.rs2     = instr_i[24:20];
    dec_p0.f.funct7  = instr_i[31:25];
    dec_p0.f.fmt     = fmt_p0;
    dec_p0.f.illegal = (opfmt_p0 == FMT_ILL) || (fmt_p0 == FMT_ILL);
    dec_p0.imm       = imm_p0;
  end

  assign accept = in_valid && in_ready;

  // ---- stage 1: main entry and skid entry ----
  // Main refills (from skid first, else from the input) whenever it is empty
  // or draining; otherwise a new accept lands in skid. in_ready is low while
  // skid is full, so an accept never coincides with a skid refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush_i) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || out_ready) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) main_p1 <= dec_p0;
      end
    end else if (accept) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign in_ready  = !skid_vld_p1;
  assign out_valid = vld_p1;
  assign op_o      = main_p1.f.op;
  assign rd_o      = main_p1.f.rd;
  assign funct3_o  = main_p1.f.funct3;
  assign rs1_o     = main_p1.f.rs1;
  assign rs2_o     = main_p1.f.rs2;
  assign funct7_o  = main_p1.f.funct7;
  assign fmt_o     = main_p1.f.fmt;
  assign illegal_o = main_p1.f.illegal;
  assign immext_o  = main_p1.imm;

endmodule
